// File: rtl/ram_dp_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_sync_if
// Brief    : Load/store and fetch bus bundle for the ram_dp_sync memory.
// Revision : 1.0
// ============================================================================
interface ram_dp_sync_if;
    // Data port (load/store unit)
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_misalign;

    // Instruction port (fetch, read-only)
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        i_misalign;

    modport master (
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_ready, d_valid, d_rdata, d_misalign,
        output i_req, i_addr,
        input  i_ready, i_valid, i_rdata, i_misalign
    );

    modport slave (
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_ready, d_valid, d_rdata, d_misalign,
        input  i_req, i_addr,
        output i_ready, i_valid, i_rdata, i_misalign
    );
endinterface
`default_nettype wire

// File: rtl/ram_dp_sync.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_sync
// Brief    : Dual-port byte-lane RAM, registered reads, RV load extension,
//            misalign detection and configurable wait states per port.
// Revision : 1.0
// ============================================================================
module ram_dp_sync #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ram_dp_sync_if.slave  bus
);

    localparam int         c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [2:0] c_WAIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_d_idx;
    logic [c_AW-1:0] w_i_idx;
    logic            w_d_mis;
    logic            w_i_mis;
    logic            w_d_ready;
    logic            w_i_ready;
    logic            w_d_acc;
    logic            w_i_acc;
    logic [3:0]      w_d_be;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_d_word;
    logic [31:0]     w_i_word;
    logic [7:0]      w_d_byte;
    logic [15:0]     w_d_half;
    logic [31:0]     w_d_ext;
    logic            w_unused_addr;

    assign w_d_idx = bus.d_addr[c_AW+1:2];
    assign w_i_idx = bus.i_addr[c_AW+1:2];

    // Upper address bits are ignored so accesses wrap modulo the RAM size.
    assign w_unused_addr = ^{bus.d_addr[31:c_AW+2], bus.i_addr[31:c_AW+2]};

    always_comb begin
        w_d_mis = 1'b0;
        case (bus.d_size)
            2'd0:    w_d_mis = 1'b0;
            2'd1:    w_d_mis = bus.d_addr[0];
            2'd2:    w_d_mis = (bus.d_addr[1:0] != 2'd0);
            default: w_d_mis = 1'b1;
        endcase
    end

    assign w_i_mis = (bus.i_addr[1:0] != 2'd0);

    assign w_d_acc = bus.d_req & w_d_ready;
    assign w_i_acc = bus.i_req & w_i_ready;

    always_comb begin
        w_d_be      = 4'b0000;
        w_wdata_rep = bus.d_wdata;
        case (bus.d_size)
            2'd0: begin
                w_d_be      = 4'b0001 << bus.d_addr[1:0];
                w_wdata_rep = {4{bus.d_wdata[7:0]}};
            end
            2'd1: begin
                w_d_be      = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                w_d_be      = 4'b1111;
                w_wdata_rep = bus.d_wdata;
            end
        endcase
        if (!(w_d_acc && bus.d_we && !w_d_mis)) begin
            w_d_be = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Storage: one array per byte lane; reads see pre-write contents
    // ------------------------------------------------------------------
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (w_d_be[l]) begin
                mem_q[w_d_idx] <= w_wdata_rep[8*l +: 8];
            end
        end

        assign w_d_word[8*l +: 8] = mem_q[w_d_idx];
        assign w_i_word[8*l +: 8] = mem_q[w_i_idx];
    end

    // ------------------------------------------------------------------
    // Load extension
    // ------------------------------------------------------------------
    always_comb begin
        w_d_byte = w_d_word[{bus.d_addr[1:0], 3'b000} +: 8];
        w_d_half = bus.d_addr[1] ? w_d_word[31:16] : w_d_word[15:0];
        w_d_ext  = w_d_word;
        case (bus.d_size)
            2'd0:    w_d_ext = bus.d_unsigned ? {24'd0, w_d_byte}
                                              : {{24{w_d_byte[7]}}, w_d_byte};
            2'd1:    w_d_ext = bus.d_unsigned ? {16'd0, w_d_half}
                                              : {{16{w_d_half[15]}}, w_d_half};
            default: w_d_ext = w_d_word;
        endcase
        if (bus.d_we || w_d_mis) begin
            w_d_ext = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Response registers, captured at the accept edge
    // ------------------------------------------------------------------
    logic [31:0] d_rdata_q;
    logic        d_mis_q;
    logic [31:0] i_rdata_q;
    logic        i_mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata_q <= 32'd0;
            d_mis_q   <= 1'b0;
        end else if (w_d_acc) begin
            d_rdata_q <= w_d_ext;
            d_mis_q   <= w_d_mis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata_q <= 32'd0;
            i_mis_q   <= 1'b0;
        end else if (w_i_acc) begin
            i_rdata_q <= w_i_mis ? 32'd0 : w_i_word;
            i_mis_q   <= w_i_mis;
        end
    end

    // ------------------------------------------------------------------
    // Data-port handshake FSM
    // ------------------------------------------------------------------
    state_t     d_state_q;
    state_t     d_state_d;
    logic [2:0] d_cnt_q;
    logic [2:0] d_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_q <= ST_IDLE;
            d_cnt_q   <= 3'd0;
        end else begin
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
        end
    end

    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        case (d_state_q)
            ST_WAIT: begin
                d_cnt_d = d_cnt_q - 3'd1;
                if (d_cnt_q <= 3'd1) begin
                    d_state_d = ST_RESP;
                    d_cnt_d   = 3'd0;
                end
            end
            default: begin
                if (w_d_acc) begin
                    if (c_WAIT == 3'd0) begin
                        d_state_d = ST_RESP;
                    end else begin
                        d_state_d = ST_WAIT;
                        d_cnt_d   = c_WAIT;
                    end
                end else begin
                    d_state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign w_d_ready = (d_state_q != ST_WAIT);

    // ------------------------------------------------------------------
    // Fetch-port handshake FSM
    // ------------------------------------------------------------------
    state_t     i_state_q;
    state_t     i_state_d;
    logic [2:0] i_cnt_q;
    logic [2:0] i_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q <= ST_IDLE;
            i_cnt_q   <= 3'd0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
        end
    end

    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        case (i_state_q)
            ST_WAIT: begin
                i_cnt_d = i_cnt_q - 3'd1;
                if (i_cnt_q <= 3'd1) begin
                    i_state_d = ST_RESP;
                    i_cnt_d   = 3'd0;
                end
            end
            default: begin
                if (w_i_acc) begin
                    if (c_WAIT == 3'd0) begin
                        i_state_d = ST_RESP;
                    end else begin
                        i_state_d = ST_WAIT;
                        i_cnt_d   = c_WAIT;
                    end
                end else begin
                    i_state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign w_i_ready = (i_state_q != ST_WAIT);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.d_ready    = w_d_ready;
    assign bus.d_valid    = (d_state_q == ST_RESP);
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_misalign = d_mis_q;

    assign bus.i_ready    = w_i_ready;
    assign bus.i_valid    = (i_state_q == ST_RESP);
    assign bus.i_rdata    = i_rdata_q;
    assign bus.i_misalign = i_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_sync
// Brief    : Self-checking bench for ram_dp_sync (0, 2 and 3 wait states).
// Revision : 1.0
// ============================================================================
module tb_ram_dp_sync;

    logic clk = 1'b0;
    logic rst0;
    logic rst2;
    logic rst3;

    always #5 clk = ~clk;

    ram_dp_sync_if bus0 ();
    ram_dp_sync_if bus2 ();
    ram_dp_sync_if bus3 ();

    ram_dp_sync #(.DEPTH_WORDS(256),  .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    ram_dp_sync #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    ram_dp_sync #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t dq[$];
    exp_t iq[$];
    exp_t de;
    exp_t ie;

    task automatic add(input string n, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input logic mis);
        vec_t v;
        v.name = n; v.we = we; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp = exp; v.mis = mis;
        tbl.push_back(v);
    endtask

    // Drive one data request on bus0 for the coming edge and queue its expectation.
    task automatic d0_set(input vec_t v);
        exp_t e;
        bus0.d_req      = 1'b1;
        bus0.d_we       = v.we;
        bus0.d_size     = v.size;
        bus0.d_unsigned = v.uns;
        bus0.d_addr     = v.addr;
        bus0.d_wdata    = v.wdata;
        e.name = v.name; e.rdata = v.exp; e.mis = v.mis; e.cyc = cyc + 1;
        dq.push_back(e);
    endtask

    task automatic i0_set(input string n, input logic [31:0] addr,
                          input logic [31:0] exp, input logic mis);
        exp_t e;
        bus0.i_req  = 1'b1;
        bus0.i_addr = addr;
        e.name = n; e.rdata = exp; e.mis = mis; e.cyc = cyc + 1;
        iq.push_back(e);
    endtask

    // Scoreboard for the zero-wait-state instance: data, flag and latency.
    always @(negedge clk) begin
        if (rst0 === 1'b0) begin
            chk("d0_ready_always", {31'd0, bus0.d_ready}, 32'd1);
            if (bus0.d_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("d0_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk({de.name, "_rdata"}, bus0.d_rdata, de.rdata);
                    chk({de.name, "_mis"}, {31'd0, bus0.d_misalign}, {31'd0, de.mis});
                    chk({de.name, "_lat"}, 32'(cyc), 32'(de.cyc));
                end
            end
            if (bus0.i_valid === 1'b1) begin
                if (iq.size() == 0) begin
                    chk("i0_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    ie = iq.pop_front();
                    chk({ie.name, "_rdata"}, bus0.i_rdata, ie.rdata);
                    chk({ie.name, "_mis"}, {31'd0, bus0.i_misalign}, {31'd0, ie.mis});
                    chk({ie.name, "_lat"}, 32'(cyc), 32'(ie.cyc));
                end
            end
        end
    end

    task automatic idle_all();
        bus0.d_req = 1'b0; bus0.i_req = 1'b0;
        bus2.d_req = 1'b0; bus2.i_req = 1'b0;
        bus3.d_req = 1'b0; bus3.i_req = 1'b0;
    endtask

    task automatic set_d(input int which, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (which == 2) begin
            bus2.d_req = 1'b1; bus2.d_we = we; bus2.d_size = size;
            bus2.d_unsigned = 1'b0; bus2.d_addr = addr; bus2.d_wdata = wdata;
        end else begin
            bus3.d_req = 1'b1; bus3.d_we = we; bus3.d_size = size;
            bus3.d_unsigned = 1'b0; bus3.d_addr = addr; bus3.d_wdata = wdata;
        end
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        bus0.d_we = 1'b0; bus0.d_size = 2'd0; bus0.d_unsigned = 1'b0;
        bus0.d_addr = 32'd0; bus0.d_wdata = 32'd0; bus0.i_addr = 32'd0;
        bus2.d_we = 1'b0; bus2.d_size = 2'd0; bus2.d_unsigned = 1'b0;
        bus2.d_addr = 32'd0; bus2.d_wdata = 32'd0; bus2.i_addr = 32'd0;
        bus3.d_we = 1'b0; bus3.d_size = 2'd0; bus3.d_unsigned = 1'b0;
        bus3.d_addr = 32'd0; bus3.d_wdata = 32'd0; bus3.i_addr = 32'd0;
        idle_all();

        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_d_ready",   {31'd0, bus0.d_ready},    32'd1);
        chk("rst_d_valid",   {31'd0, bus0.d_valid},    32'd0);
        chk("rst_d_rdata",   bus0.d_rdata,             32'd0);
        chk("rst_d_mis",     {31'd0, bus0.d_misalign}, 32'd0);
        chk("rst_i_ready",   {31'd0, bus0.i_ready},    32'd1);
        chk("rst_i_valid",   {31'd0, bus0.i_valid},    32'd0);
        chk("rst_i_rdata",   bus0.i_rdata,             32'd0);
        chk("rst_i_mis",     {31'd0, bus0.i_misalign}, 32'd0);
        chk("rst2_d_ready",  {31'd0, bus2.d_ready},    32'd1);
        chk("rst3_i_ready",  {31'd0, bus3.i_ready},    32'd1);

        // ---------------- zero wait states, back-to-back table ----------------
        add("sw40",   1, 2'd2, 0, 32'h040, 32'h12345678, 32'h00000000, 0);
        add("lb41",   0, 2'd0, 0, 32'h041, 32'h0,        32'h00000056, 0);
        add("lh42",   0, 2'd1, 0, 32'h042, 32'h0,        32'h00001234, 0);
        add("lw40",   0, 2'd2, 0, 32'h040, 32'h0,        32'h12345678, 0);
        add("sb43",   1, 2'd0, 0, 32'h043, 32'h12345680, 32'h00000000, 0);
        add("lb43",   0, 2'd0, 0, 32'h043, 32'h0,        32'hFFFFFF80, 0);
        add("lbu43",  0, 2'd0, 1, 32'h043, 32'h0,        32'h00000080, 0);
        add("lhu42",  0, 2'd1, 1, 32'h042, 32'h0,        32'h00008034, 0);
        add("lh42s",  0, 2'd1, 0, 32'h042, 32'h0,        32'hFFFF8034, 0);
        add("sh41",   1, 2'd1, 0, 32'h041, 32'h0000BEEF, 32'h00000000, 1);
        add("lw40b",  0, 2'd2, 0, 32'h040, 32'h0,        32'h80345678, 0);
        add("sz3",    0, 2'd3, 0, 32'h040, 32'h0,        32'h00000000, 1);
        add("swmis",  1, 2'd2, 0, 32'h042, 32'hFFFFFFFF, 32'h00000000, 1);
        add("lwmis",  0, 2'd2, 0, 32'h041, 32'h0,        32'h00000000, 1);
        add("lw40u",  0, 2'd2, 1, 32'h040, 32'h0,        32'h80345678, 0);
        add("lw440",  0, 2'd2, 0, 32'h440, 32'h0,        32'h80345678, 0);
        add("sw44",   1, 2'd2, 0, 32'h044, 32'h11223344, 32'h00000000, 0);
        add("sh46",   1, 2'd1, 0, 32'h046, 32'h1234CAFE, 32'h00000000, 0);
        add("lw44",   0, 2'd2, 0, 32'h044, 32'h0,        32'hCAFE3344, 0);
        add("lh44",   0, 2'd1, 0, 32'h044, 32'h0,        32'h00003344, 0);
        add("lh46",   0, 2'd1, 0, 32'h046, 32'h0,        32'hFFFFCAFE, 0);
        add("lb46",   0, 2'd0, 0, 32'h046, 32'h0,        32'hFFFFFFFE, 0);
        add("lbu45",  0, 2'd0, 1, 32'h045, 32'h0,        32'h00000033, 0);
        add("sb447",  1, 2'd0, 0, 32'h447, 32'h0000007F, 32'h00000000, 0);
        add("lw44c",  0, 2'd2, 0, 32'h044, 32'h0,        32'h7FFE3344, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            d0_set(tbl[k]);
            @(negedge clk);
        end
        bus0.d_req = 1'b0;

        i0_set("f44", 32'h044, 32'h7FFE3344, 0);
        @(negedge clk);
        i0_set("f42", 32'h042, 32'h00000000, 1);
        @(negedge clk);
        bus0.i_req = 1'b0;

        // Same-edge store and fetch: fetch sees old contents, next fetch the new.
        begin
            vec_t v;
            v.name = "sw10_init"; v.we = 1; v.size = 2'd2; v.uns = 0;
            v.addr = 32'h010; v.wdata = 32'h0; v.exp = 32'h0; v.mis = 0;
            d0_set(v);
            @(negedge clk);
            v.name = "sw10_aa"; v.wdata = 32'hAAAAAAAA;
            d0_set(v);
            i0_set("f10_old", 32'h010, 32'h00000000, 0);
            @(negedge clk);
            v.name = "lw410"; v.we = 0; v.addr = 32'h410; v.wdata = 32'h0; v.exp = 32'hAAAAAAAA;
            d0_set(v);
            i0_set("f10_new", 32'h010, 32'hAAAAAAAA, 0);
            @(negedge clk);
            idle_all();
        end

        for (int t = 0; t < 10 && (dq.size() != 0 || iq.size() != 0); t++) @(negedge clk);
        chk("drain_d0", 32'(dq.size()), 32'd0);
        chk("drain_i0", 32'(iq.size()), 32'd0);

        // ---------------- two wait states, continuous stores ----------------
        set_d(2, 1'b1, 2'd2, 32'h080, 32'hDEADBEEF);
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h081;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) bus2.i_req = 1'b0;
            chk($sformatf("w2_ready_%0d", i), {31'd0, bus2.d_ready}, {31'd0, (i % 3 == 2)});
            chk($sformatf("w2_valid_%0d", i), {31'd0, bus2.d_valid}, {31'd0, (i % 3 == 2)});
            chk($sformatf("w2_ivalid_%0d", i), {31'd0, bus2.i_valid}, {31'd0, (i == 2)});
            chk($sformatf("w2_iready_%0d", i), {31'd0, bus2.i_ready}, {31'd0, (i >= 2)});
            if (i == 2) begin
                chk("w2_imis",   {31'd0, bus2.i_misalign}, 32'd1);
                chk("w2_irdata", bus2.i_rdata,             32'd0);
                chk("w2_srdata", bus2.d_rdata,             32'd0);
            end
        end
        bus2.d_req = 1'b0;
        @(negedge clk);
        set_d(2, 1'b0, 2'd2, 32'h080, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus2.d_req = 1'b0;
            chk($sformatf("w2_lvalid_%0d", i), {31'd0, bus2.d_valid}, {31'd0, (i == 2)});
            if (i == 2) chk("w2_lrdata", bus2.d_rdata, 32'hDEADBEEF);
        end

        // ---------------- three wait states, reset during WAIT ----------------
        set_d(3, 1'b1, 2'd2, 32'h020, 32'h13579BDF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus3.d_req = 1'b0;
            chk($sformatf("w3_svalid_%0d", i), {31'd0, bus3.d_valid}, {31'd0, (i == 3)});
        end
        set_d(3, 1'b0, 2'd2, 32'h020, 32'h0);
        @(negedge clk);
        bus3.d_req = 1'b0;
        chk("w3_ready_wait", {31'd0, bus3.d_ready}, 32'd0);
        rst3 = 1'b1;
        #1;
        chk("w3_rst_ready", {31'd0, bus3.d_ready}, 32'd1);
        chk("w3_rst_valid", {31'd0, bus3.d_valid}, 32'd0);
        chk("w3_rst_rdata", bus3.d_rdata,          32'd0);
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("w3_post_valid_%0d", i), {31'd0, bus3.d_valid}, 32'd0);
            chk($sformatf("w3_post_ready_%0d", i), {31'd0, bus3.d_ready}, 32'd1);
        end
        set_d(3, 1'b0, 2'd2, 32'h020, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus3.d_req = 1'b0;
            chk($sformatf("w3_lvalid_%0d", i), {31'd0, bus3.d_valid}, {31'd0, (i == 3)});
            if (i == 3) chk("w3_lrdata", bus3.d_rdata, 32'h13579BDF);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
